multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main controller for the multi-cycle MIPS datapath: one shared memory, one ALU, IR/A/B/ALUOut holding registers.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives every datapath mux and enable.
//  Stalls on a memory ready handshake; traps on illegal opcodes and memory timeouts.
// PARAMETERS
//  WAIT_LIMIT  16  max wait cycles per memory access in FETCH/MEM_READ/MEM_WRITE; 0 = no limit; legal 0..255
// PORTS
//  Clk               in   1  clock, rising edge
//  Reset_N           in   1  asynchronous, active-low reset
//  Opcode            in   6  IR[31:26]; valid from DECODE onward
//  Mem_Ready         in   1  memory completes the current access this cycle
//  PC_Write          out  1  unconditional PC load
//  Branch            out  1  PC load if ALU Zero=1 (beq)
//  Branch_Not_Equal  out  1  PC load if ALU Zero=0 (bne)
//  I_or_D            out  1  memory address: 0=PC, 1=ALUOut
//  Mem_Read          out  1  memory read strobe
//  Mem_Write         out  1  memory write strobe
//  IR_Write          out  1  IR load
//  Reg_Dst           out  2  00=rt, 01=rd, 10=$31
//  Mem_to_Reg        out  2  00=ALUOut, 01=MDR, 10=PC
//  Reg_Write         out  1  register file write
//  ALU_Src_A         out  1  0=PC, 1=A
//  ALU_Src_B         out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//  ALU_Op            out  3  000 ADD, 001 SUB, 010 RTYPE(funct), 011 AND, 100 OR, 101 SLT, 110 XOR, 111 LUI
//  PC_Source         out  2  00=ALU result, 01=ALUOut, 10=jump target
//  Fault             out  2  sticky: 00 none, 01 illegal opcode, 10 memory timeout
// BEHAVIOUR
//  - Registered: state (4b), Op_Q (6b, Opcode captured on exit from DECODE), wait counter (8b), Fault. Outputs are combinational from these plus Mem_Ready.
//  - Reset (async, Reset_N=0): state=IDLE, Op_Q=0, counter=0, Fault=00. All outputs 0 immediately, including mid-access (Mem_Write drops).
//  - Any output not listed for a state is 0 (never x/z).
//  - IDLE: -> FETCH next cycle.
//  - FETCH: Mem_Read=1, I_or_D=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Op=ADD, PC_Source=00.
//    IR_Write and PC_Write = Mem_Ready (same cycle). Mem_Ready=1 -> DECODE; otherwise hold.
//  - DECODE: ALU_Src_A=0, ALU_Src_B=11, ALU_Op=ADD. Latch Op_Q. Next state by Opcode:
//    0 -> EXECUTE; 35/43 -> MEM_ADDR; 4/5 -> BRANCH; 2/3 -> JUMP; 8/10/12/13/14/15 -> IMM_EXEC (macro-gated); other -> TRAP, Fault=01.
//  - MEM_ADDR: ALU_Src_A=1, ALU_Src_B=10, ADD -> MEM_READ (lw) or MEM_WRITE (sw).
//  - MEM_READ: I_or_D=1, Mem_Read=1; hold until Mem_Ready -> MEM_WB.
//  - MEM_WB: Reg_Dst=00, Mem_to_Reg=01, Reg_Write=1 -> FETCH.
//  - MEM_WRITE: I_or_D=1, Mem_Write=1; hold until Mem_Ready -> FETCH.
//  - EXECUTE: ALU_Src_A=1, ALU_Src_B=00, RTYPE -> R_WB.
//  - R_WB: Reg_Dst=01, Reg_Write=1 -> FETCH.
//  - BRANCH: ALU_Src_A=1, ALU_Src_B=00, SUB, PC_Source=01. Branch=1 if Op_Q=4, Branch_Not_Equal=1 if Op_Q=5 -> FETCH.
//  - JUMP: PC_Write=1, PC_Source=10. If Op_Q=3 also Reg_Dst=10, Mem_to_Reg=10, Reg_Write=1 (PC already +4) -> FETCH.
//  - IMM_EXEC: ALU_Src_A=1, ALU_Src_B=10. ALU_Op by Op_Q: 8 ADD, 12 AND, 13 OR, 10 SLT, 14 XOR, 15 LUI -> IMM_WB.
//  - IMM_WB: Reg_Dst=00, Mem_to_Reg=00, Reg_Write=1 -> FETCH.
//  - TRAP: all outputs 0; stays until reset.
//  - Latency with zero-wait memory: R/imm 4 cycles, lw 5, sw 4, beq/bne/j/jal 3.
//  - Wait counter: cleared on entry to any memory state. Increments each cycle there with Mem_Ready=0.
//    If WAIT_LIMIT!=0 and counter==WAIT_LIMIT with Mem_Ready=0: strobes drop next cycle, -> TRAP, Fault=10.
//    Mem_Ready=1 in that same cycle completes normally.
//  - Fault is written only on entry to TRAP; first cause wins.
// CONFIGURATION
//  MIPS_MC_IMM_OPS_EN defined: IMM_EXEC/IMM_WB present; opcodes 8,10,12,13,14,15 execute as above.
//  Not defined: those states are absent and the opcodes take the illegal path (TRAP, Fault=01).
// STRUCTURE
//  Package mips_mc_pkg: state localparams (IDLE..IMM_WB, TRAP=4'hF), opcode constants, ALU_Op codes, Reg_Dst/Mem_to_Reg/ALU_Src_B/PC_Source select codes, Fault codes.
//  Sub-module mc_output_decode: combinational {state, Op_Q, Mem_Ready} -> control outputs. Top holds state, Op_Q, counter, Fault.
// TESTING
//  - Reset_N=0 mid MEM_WRITE with Mem_Write=1 -> all outputs 0 same cycle; after release IDLE, then FETCH with Mem_Read=1.
//  - Opcode=0, Mem_Ready=1 always -> FETCH,DECODE,EXECUTE(ALU_Op=010),R_WB(Reg_Dst=01,Reg_Write=1); next FETCH on cycle 5.
//  - lw (35), Mem_Ready low 3 cycles in MEM_READ -> Mem_Read held 4 cycles; MEM_WB asserts Mem_to_Reg=01 once.
//  - jal (3) -> JUMP: PC_Write=1, PC_Source=10, Reg_Dst=10, Mem_to_Reg=10, Reg_Write=1. j (2) -> same, Reg_Write=0.
//  - WAIT_LIMIT=4, Mem_Ready stuck 0 in FETCH -> TRAP after 5 FETCH cycles, Fault=10; opcode 6'd63 -> TRAP, Fault=01.
//  - Opcode 13 with/without MIPS_MC_IMM_OPS_EN -> IMM_EXEC ALU_Op=100 / TRAP Fault=01.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM.
// Holds the state encoding, the opcode constants the decoder recognises,
// the ALU operation codes, the datapath mux select codes, the fault codes,
// and the packed control bundle passed from the output decoder to the top.
// Optional feature macro: MIPS_MC_IMM_OPS_EN. The state codes for
// IMM_EXEC/IMM_WB are always defined here. They are only reachable when
// the macro is defined.
package mips_mc_pkg;

  // TRAP sits at the top of the encoding so it is easy to spot on a bus.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'h0,
    ST_FETCH     = 4'h1,
    ST_DECODE    = 4'h2,
    ST_MEM_ADDR  = 4'h3,
    ST_MEM_READ  = 4'h4,
    ST_MEM_WB    = 4'h5,
    ST_MEM_WRITE = 4'h6,
    ST_EXECUTE   = 4'h7,
    ST_R_WB      = 4'h8,
    ST_BRANCH    = 4'h9,
    ST_JUMP      = 4'hA,
    ST_IMM_EXEC  = 4'hB,
    ST_IMM_WB    = 4'hC,
    ST_TRAP      = 4'hF
  } state_e;

  // Opcodes taken from IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;
  localparam logic [2:0] ALU_LUI   = 3'b111;

  // Register file destination select
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  // Register file write data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // ALU operand B select
  localparam logic [2-1:0] SRCB_B      = 2'b00;
  localparam logic [1:0]   SRCB_FOUR   = 2'b01;
  localparam logic [1:0]   SRCB_IMM    = 2'b10;
  localparam logic [1:0]   SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Sticky fault codes
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // Complete set of datapath controls driven by the FSM
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for the states that wait on the memory ready handshake
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational output decoder for the multi-cycle MIPS controller.
// Maps the current state, the latched opcode and the memory ready flag
// onto every datapath mux select and enable. Any control that a state does
// not use is driven to zero.
// Optional feature macro: MIPS_MC_IMM_OPS_EN adds the IMM_EXEC/IMM_WB decode.
// Ports:
//   state_i     current FSM state
//   op_q_i      opcode latched on exit from DECODE
//   mem_ready_i memory completes the current access this cycle
//   ctrl_o      packed control bundle
module mc_output_decode
  import mips_mc_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_q_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // Per-state control decode. Every control starts at zero, so IDLE, TRAP and
  // any unused encoding produce an all-zero bundle.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        // PC+4 goes through the ALU while the instruction is read. PC and IR
        // load only in the cycle the memory completes.
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.i_or_d    = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        // Speculative branch target computed while the opcode is decoded
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      ST_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      ST_MEM_READ: begin
        ctrl_o.i_or_d   = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl_o.reg_dst    = REG_DST_RT;
        ctrl_o.mem_to_reg = M2R_MDR;
        ctrl_o.reg_write  = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_RTYPE;
      end
      ST_R_WB: begin
        ctrl_o.reg_dst   = REG_DST_RD;
        ctrl_o.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        // Compare by subtraction. The PC loads the target saved in ALUOut
        // during DECODE, qualified by Zero outside this block.
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_source = PCSRC_ALUOUT;
        ctrl_o.branch    = (op_q_i == OP_BEQ);
        ctrl_o.branch_ne = (op_q_i == OP_BNE);
      end
      ST_JUMP: begin
        // For jal the PC still holds PC+4 from FETCH, so it becomes the link.
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
        if (op_q_i == OP_JAL) begin
          ctrl_o.reg_dst    = REG_DST_RA;
          ctrl_o.mem_to_reg = M2R_PC;
          ctrl_o.reg_write  = 1'b1;
        end
      end
`ifdef MIPS_MC_IMM_OPS_EN
      ST_IMM_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        case (op_q_i)
          OP_ANDI: ctrl_o.alu_op = ALU_AND;
          OP_ORI:  ctrl_o.alu_op = ALU_OR;
          OP_SLTI: ctrl_o.alu_op = ALU_SLT;
          OP_XORI: ctrl_o.alu_op = ALU_XOR;
          OP_LUI:  ctrl_o.alu_op = ALU_LUI;
          default: ctrl_o.alu_op = ALU_ADD;
        endcase
      end
      ST_IMM_WB: begin
        ctrl_o.reg_dst    = REG_DST_RT;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main controller for the multi-cycle MIPS datapath (shared memory, single
// ALU, IR/A/B/ALUOut holding registers). It sequences each instruction
// through fetch, decode, execute, memory and writeback. It stalls on the
// memory ready handshake. It traps on illegal opcodes and on memory
// accesses that exceed WAIT_LIMIT wait cycles.
// Optional feature macro: MIPS_MC_IMM_OPS_EN enables the immediate ALU ops
// (addi, slti, andi, ori, xori, lui). Without it those opcodes trap as illegal.
// Parameters:
//   WAIT_LIMIT  max wait cycles per memory access, 0 = unlimited (0..255)
// Ports:
//   Clk, Reset_N              clock (rising edge), async active-low reset
//   Opcode                    IR[31:26], valid from DECODE onward
//   Mem_Ready                 memory completes the current access
//   PC_Write, Branch, Branch_Not_Equal, PC_Source   PC update controls
//   I_or_D, Mem_Read, Mem_Write, IR_Write           memory/IR controls
//   Reg_Dst, Mem_to_Reg, Reg_Write                  register file controls
//   ALU_Src_A, ALU_Src_B, ALU_Op                    ALU controls
//   Fault                     sticky fault code (00 none, 01 illegal, 10 timeout)
module multicycle_control_fsm
  import mips_mc_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic       Clk,
  input  logic       Reset_N,
  input  logic [5:0] Opcode,
  input  logic       Mem_Ready,
  output logic       PC_Write,
  output logic       Branch,
  output logic       Branch_Not_Equal,
  output logic       I_or_D,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic [1:0] Reg_Dst,
  output logic [1:0] Mem_to_Reg,
  output logic       Reg_Write,
  output logic       ALU_Src_A,
  output logic [1:0] ALU_Src_B,
  output logic [2:0] ALU_Op,
  output logic [1:0] PC_Source,
  output logic [1:0] Fault
);

  localparam logic [7:0] WaitLimitC = 8'(WAIT_LIMIT);
  localparam bit         LimitEnC   = (WAIT_LIMIT != 0);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] fault_q, fault_d;
  logic       timeout;
  ctrl_t      ctrl;

  // The access expires only when the limit is reached and the memory is
  // still not ready. A ready in that same cycle completes normally.
  assign timeout = LimitEnC && (wait_cnt_q == WaitLimitC) && !Mem_Ready;

  // Next-state logic. The wait counter defaults to zero, so every entry into
  // a memory state starts a fresh count. It only advances while a memory
  // state is held waiting. The fault code changes only on the transition
  // into TRAP. TRAP is left only through reset, so the first cause sticks.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_cnt_d = '0;
    fault_d    = fault_q;

    if (is_mem_state(state_q) && !Mem_Ready) begin
      if (timeout) begin
        state_d = ST_TRAP;
        fault_d = FAULT_TIMEOUT;
      end else begin
        wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
      end
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_FETCH;
        ST_FETCH:     state_d = ST_DECODE;
        ST_DECODE: begin
          op_d = Opcode;
          case (Opcode)
            OP_RTYPE:      state_d = ST_EXECUTE;
            OP_LW, OP_SW:  state_d = ST_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = ST_BRANCH;
            OP_J, OP_JAL:  state_d = ST_JUMP;
`ifdef MIPS_MC_IMM_OPS_EN
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                           state_d = ST_IMM_EXEC;
`endif
            default: begin
              state_d = ST_TRAP;
              fault_d = FAULT_ILLEGAL;
            end
          endcase
        end
        ST_MEM_ADDR:  state_d = (op_q == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
        ST_MEM_READ:  state_d = ST_MEM_WB;
        ST_MEM_WB:    state_d = ST_FETCH;
        ST_MEM_WRITE: state_d = ST_FETCH;
        ST_EXECUTE:   state_d = ST_R_WB;
        ST_R_WB:      state_d = ST_FETCH;
        ST_BRANCH:    state_d = ST_FETCH;
        ST_JUMP:      state_d = ST_FETCH;
`ifdef MIPS_MC_IMM_OPS_EN
        ST_IMM_EXEC:  state_d = ST_IMM_WB;
        ST_IMM_WB:    state_d = ST_FETCH;
`endif
        ST_TRAP:      state_d = ST_TRAP;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // State registers. Reset forces IDLE, which decodes to all-zero outputs
  // immediately, even in the middle of a memory access.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      wait_cnt_q <= '0;
      fault_q    <= FAULT_NONE;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  mc_output_decode u_decode (
    .state_i     (state_q),
    .op_q_i      (op_q),
    .mem_ready_i (Mem_Ready),
    .ctrl_o      (ctrl)
  );

  assign PC_Write         = ctrl.pc_write;
  assign Branch           = ctrl.branch;
  assign Branch_Not_Equal = ctrl.branch_ne;
  assign I_or_D           = ctrl.i_or_d;
  assign Mem_Read         = ctrl.mem_read;
  assign Mem_Write        = ctrl.mem_write;
  assign IR_Write         = ctrl.ir_write;
  assign Reg_Dst          = ctrl.reg_dst;
  assign Mem_to_Reg       = ctrl.mem_to_reg;
  assign Reg_Write        = ctrl.reg_write;
  assign ALU_Src_A        = ctrl.alu_src_a;
  assign ALU_Src_B        = ctrl.alu_src_b;
  assign ALU_Op           = ctrl.alu_op;
  assign PC_Source        = ctrl.pc_source;
  assign Fault            = fault_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm with WAIT_LIMIT=4.
// Inputs change just after each falling edge. Outputs are sampled 1 ns later.
// Expected control bundles are hand-written constants. The immediate-op
// scenario follows MIPS_MC_IMM_OPS_EN.
module tb_multicycle_control_fsm;

  logic       Clk;
  logic       Reset_N;
  logic [5:0] Opcode;
  logic       Mem_Ready;
  logic       PC_Write, Branch, Branch_Not_Equal, I_or_D, Mem_Read, Mem_Write;
  logic       IR_Write, Reg_Write, ALU_Src_A;
  logic [1:0] Reg_Dst, Mem_to_Reg, ALU_Src_B, PC_Source, Fault;
  logic [2:0] ALU_Op;

  int errors = 0;
  int checks = 0;

  multicycle_control_fsm #(.WAIT_LIMIT(4)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .Opcode(Opcode), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .Branch(Branch), .Branch_Not_Equal(Branch_Not_Equal),
    .I_or_D(I_or_D), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .IR_Write(IR_Write), .Reg_Dst(Reg_Dst), .Mem_to_Reg(Mem_to_Reg),
    .Reg_Write(Reg_Write), .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B),
    .ALU_Op(ALU_Op), .PC_Source(PC_Source), .Fault(Fault)
  );

  // All control outputs flattened in a fixed order for whole-bundle compares
  logic [19:0] ctrl;
  assign ctrl = {PC_Write, Branch, Branch_Not_Equal, I_or_D, Mem_Read,
                 Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write,
                 ALU_Src_A, ALU_Src_B, ALU_Op, PC_Source};

  function automatic logic [19:0] mk(
    input logic pcw, input logic br, input logic bne, input logic iord,
    input logic mr, input logic mw, input logic irw, input logic [1:0] rd,
    input logic [1:0] m2r, input logic rw, input logic sa, input logic [1:0] sb,
    input logic [2:0] op, input logic [1:0] ps);
    return {pcw, br, bne, iord, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps};
  endfunction

  localparam logic [19:0] E_ZERO       = 20'h0;
  localparam logic [19:0] E_FETCH_WAIT = mk(0,0,0,0,1,0,0,2'b00,2'b00,0,0,2'b01,3'b000,2'b00);
  localparam logic [19:0] E_FETCH_RDY  = mk(1,0,0,0,1,0,1,2'b00,2'b00,0,0,2'b01,3'b000,2'b00);
  localparam logic [19:0] E_DECODE     = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,3'b000,2'b00);
  localparam logic [19:0] E_EXEC       = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b010,2'b00);
  localparam logic [19:0] E_RWB        = mk(0,0,0,0,0,0,0,2'b01,2'b00,1,0,2'b00,3'b000,2'b00);
  localparam logic [19:0] E_MEMADDR    = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b000,2'b00);
  localparam logic [19:0] E_MEMRD      = mk(0,0,0,1,1,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00);
  localparam logic [19:0] E_MEMWB      = mk(0,0,0,0,0,0,0,2'b00,2'b01,1,0,2'b00,3'b000,2'b00);
  localparam logic [19:0] E_MEMWR      = mk(0,0,0,1,0,1,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00);
  localparam logic [19:0] E_BEQ        = mk(0,1,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b001,2'b01);
  localparam logic [19:0] E_BNE        = mk(0,0,1,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b001,2'b01);
  localparam logic [19:0] E_J          = mk(1,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b10);
  localparam logic [19:0] E_JAL        = mk(1,0,0,0,0,0,0,2'b10,2'b10,1,0,2'b00,3'b000,2'b10);
`ifdef MIPS_MC_IMM_OPS_EN
  localparam logic [19:0] E_ORI        = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b100,2'b00);
  localparam logic [19:0] E_IMMWB      = mk(0,0,0,0,0,0,0,2'b00,2'b00,1,0,2'b00,3'b000,2'b00);
`endif

  // Free-running 10 ns clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Safety net so the run always ends even if the clock stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one cycle, apply inputs after the falling edge, let outputs settle
  task automatic step(input logic rdy, input logic [5:0] op);
    @(negedge Clk);
    Mem_Ready = rdy;
    Opcode    = op;
    #1;
  endtask

  // Pulse reset. On return the DUT is in IDLE and the next step shows FETCH.
  task automatic do_reset();
    @(negedge Clk);
    Reset_N = 1'b0; Mem_Ready = 1'b0; Opcode = 6'd0;
    @(negedge Clk);
    Reset_N = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    Reset_N = 1'b0; Mem_Ready = 1'b0; Opcode = 6'd0;
    repeat (2) @(negedge Clk);
    #1;
    checks++; if (ctrl !== E_ZERO) begin errors++; $display("[TB] FAIL reset_ctrl: got %h expected %h", ctrl, E_ZERO); end
    checks++; if (Fault !== 2'b00) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 00", Fault); end
    @(negedge Clk);
    Reset_N = 1'b1;
    #1;
    checks++; if (ctrl !== E_ZERO) begin errors++; $display("[TB] FAIL idle_ctrl: got %h expected %h", ctrl, E_ZERO); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_FETCH_WAIT) begin errors++; $display("[TB] FAIL first_fetch: got %h expected %h", ctrl, E_FETCH_WAIT); end
  endtask

  task automatic test_rtype();
    step(1'b1, 6'd0);
    checks++; if (ctrl !== E_FETCH_RDY) begin errors++; $display("[TB] FAIL r_fetch: got %h expected %h", ctrl, E_FETCH_RDY); end
    step(1'b1, 6'd0);
    checks++; if (ctrl !== E_DECODE) begin errors++; $display("[TB] FAIL r_decode: got %h expected %h", ctrl, E_DECODE); end
    step(1'b1, 6'd0);
    checks++; if (ctrl !== E_EXEC) begin errors++; $display("[TB] FAIL r_exec: got %h expected %h", ctrl, E_EXEC); end
    step(1'b1, 6'd0);
    checks++; if (ctrl !== E_RWB) begin errors++; $display("[TB] FAIL r_wb: got %h expected %h", ctrl, E_RWB); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_FETCH_WAIT) begin errors++; $display("[TB] FAIL r_next_fetch: got %h expected %h", ctrl, E_FETCH_WAIT); end
  endtask

  task automatic test_lw_wait();
    step(1'b1, 6'd35);
    checks++; if (ctrl !== E_FETCH_RDY) begin errors++; $display("[TB] FAIL lw_fetch: got %h expected %h", ctrl, E_FETCH_RDY); end
    step(1'b0, 6'd35);
    checks++; if (ctrl !== E_DECODE) begin errors++; $display("[TB] FAIL lw_decode: got %h expected %h", ctrl, E_DECODE); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_MEMADDR) begin errors++; $display("[TB] FAIL lw_addr: got %h expected %h", ctrl, E_MEMADDR); end
    for (int i = 0; i < 4; i++) begin
      step((i == 3) ? 1'b1 : 1'b0, 6'd0);
      checks++; if (ctrl !== E_MEMRD) begin errors++; $display("[TB] FAIL lw_read%0d: got %h expected %h", i, ctrl, E_MEMRD); end
    end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_MEMWB) begin errors++; $display("[TB] FAIL lw_wb: got %h expected %h", ctrl, E_MEMWB); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_FETCH_WAIT) begin errors++; $display("[TB] FAIL lw_next_fetch: got %h expected %h", ctrl, E_FETCH_WAIT); end
  endtask

  task automatic test_sw_reset_mid_write();
    step(1'b1, 6'd43);
    step(1'b0, 6'd43);
    checks++; if (ctrl !== E_DECODE) begin errors++; $display("[TB] FAIL sw_decode: got %h expected %h", ctrl, E_DECODE); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_MEMADDR) begin errors++; $display("[TB] FAIL sw_addr: got %h expected %h", ctrl, E_MEMADDR); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_MEMWR) begin errors++; $display("[TB] FAIL sw_write: got %h expected %h", ctrl, E_MEMWR); end
    #1 Reset_N = 1'b0;
    #1;
    checks++; if (ctrl !== E_ZERO) begin errors++; $display("[TB] FAIL sw_async_reset: got %h expected %h", ctrl, E_ZERO); end
    @(negedge Clk);
    Reset_N = 1'b1;
    #1;
    checks++; if (ctrl !== E_ZERO) begin errors++; $display("[TB] FAIL sw_reset_idle: got %h expected %h", ctrl, E_ZERO); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_FETCH_WAIT) begin errors++; $display("[TB] FAIL sw_reset_fetch: got %h expected %h", ctrl, E_FETCH_WAIT); end
  endtask

  task automatic test_sw_complete();
    step(1'b1, 6'd43);
    step(1'b0, 6'd43);
    step(1'b0, 6'd0);
    step(1'b1, 6'd0);
    checks++; if (ctrl !== E_MEMWR) begin errors++; $display("[TB] FAIL sw_ready_write: got %h expected %h", ctrl, E_MEMWR); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_FETCH_WAIT) begin errors++; $display("[TB] FAIL sw_next_fetch: got %h expected %h", ctrl, E_FETCH_WAIT); end
  endtask

  task automatic test_branch();
    step(1'b1, 6'd4);
    step(1'b0, 6'd4);
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_BEQ) begin errors++; $display("[TB] FAIL beq: got %h expected %h", ctrl, E_BEQ); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_FETCH_WAIT) begin errors++; $display("[TB] FAIL beq_next_fetch: got %h expected %h", ctrl, E_FETCH_WAIT); end
    step(1'b1, 6'd5);
    step(1'b0, 6'd5);
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_BNE) begin errors++; $display("[TB] FAIL bne: got %h expected %h", ctrl, E_BNE); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_FETCH_WAIT) begin errors++; $display("[TB] FAIL bne_next_fetch: got %h expected %h", ctrl, E_FETCH_WAIT); end
  endtask

  task automatic test_jump();
    step(1'b1, 6'd3);
    step(1'b0, 6'd3);
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_JAL) begin errors++; $display("[TB] FAIL jal: got %h expected %h", ctrl, E_JAL); end
    step(1'b1, 6'd2);
    checks++; if (ctrl !== E_FETCH_RDY) begin errors++; $display("[TB] FAIL j_fetch: got %h expected %h", ctrl, E_FETCH_RDY); end
    step(1'b0, 6'd2);
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_J) begin errors++; $display("[TB] FAIL j: got %h expected %h", ctrl, E_J); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_FETCH_WAIT) begin errors++; $display("[TB] FAIL j_next_fetch: got %h expected %h", ctrl, E_FETCH_WAIT); end
  endtask

  task automatic test_imm();
    step(1'b1, 6'd13);
    step(1'b0, 6'd13);
    step(1'b0, 6'd0);
`ifdef MIPS_MC_IMM_OPS_EN
    checks++; if (ctrl !== E_ORI) begin errors++; $display("[TB] FAIL ori_exec: got %h expected %h", ctrl, E_ORI); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_IMMWB) begin errors++; $display("[TB] FAIL ori_wb: got %h expected %h", ctrl, E_IMMWB); end
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_FETCH_WAIT) begin errors++; $display("[TB] FAIL ori_next_fetch: got %h expected %h", ctrl, E_FETCH_WAIT); end
`else
    checks++; if (ctrl !== E_ZERO) begin errors++; $display("[TB] FAIL ori_trap: got %h expected %h", ctrl, E_ZERO); end
    checks++; if (Fault !== 2'b01) begin errors++; $display("[TB] FAIL ori_fault: got %b expected 01", Fault); end
    do_reset();
    step(1'b0, 6'd0);
`endif
  endtask

  task automatic test_illegal();
    step(1'b1, 6'd63);
    step(1'b0, 6'd63);
    step(1'b0, 6'd0);
    checks++; if (ctrl !== E_ZERO) begin errors++; $display("[TB] FAIL illegal_trap: got %h expected %h", ctrl, E_ZERO); end
    checks++; if (Fault !== 2'b01) begin errors++; $display("[TB] FAIL illegal_fault: got %b expected 01", Fault); end
    step(1'b1, 6'd0);
    step(1'b1, 6'd0);
    checks++; if (ctrl !== E_ZERO) begin errors++; $display("[TB] FAIL illegal_stays: got %h expected %h", ctrl, E_ZERO); end
    do_reset();
    checks++; if (Fault !== 2'b00) begin errors++; $display("[TB] FAIL illegal_fault_clear: got %b expected 00", Fault); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 6'd0);
      checks++; if (ctrl !== E_FETCH_WAIT) begin errors++; $display("[TB] FAIL to_fetch%0d: got %h expected %h", i, ctrl, E_FETCH_WAIT); end
    end
    step(1'b1, 6'd0);
    checks++; if (ctrl !== E_ZERO) begin errors++; $display("[TB] FAIL to_trap: got %h expected %h", ctrl, E_ZERO); end
    checks++; if (Fault !== 2'b10) begin errors++; $display("[TB] FAIL to_fault: got %b expected 10", Fault); end
    do_reset();
  endtask

  task automatic test_limit_ready();
    for (int i = 0; i < 4; i++) step(1'b0, 6'd0);
    step(1'b1, 6'd2);
    checks++; if (ctrl !== E_FETCH_RDY) begin errors++; $display("[TB] FAIL lim_fetch_ready: got %h expected %h", ctrl, E_FETCH_RDY); end
    step(1'b0, 6'd2);
    checks++; if (ctrl !== E_DECODE) begin errors++; $display("[TB] FAIL lim_decode: got %h expected %h", ctrl, E_DECODE); end
    checks++; if (Fault !== 2'b00) begin errors++; $display("[TB] FAIL lim_fault: got %b expected 00", Fault); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_reset_mid_write();
    test_sw_complete();
    test_branch();
    test_jump();
    test_imm();
    test_illegal();
    test_timeout();
    test_limit_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
